// File: rtl/exhaustive_stim_pkg.sv
// rtl/exhaustive_stim_pkg.sv - shared state type and default constants for the exhaustive stimulus/capture engine
package exhaustive_stim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } stim_state_t;

    localparam logic [15:0] DEF_POLY  = 16'h1021;
    localparam int          DEF_SIG_W = 16;

endpackage

// File: rtl/stim_misr.sv
// rtl/stim_misr.sv - multiple-input signature register folding each accepted response into sig
module stim_misr
    import exhaustive_stim_pkg::*;
#(
    parameter int               SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter int               N_OUT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] data,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= (sig << 1) ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(data);
        end
    end

endmodule

// File: rtl/exhaustive_stim_capture.sv
// rtl/exhaustive_stim_capture.sv - walks all 2^N_IN patterns into a DUT and streams (pattern, response) records
// Optional response signature under EXHAUSTIVE_STIM_CAPTURE_MISR_EN; signature is tied to 0 otherwise.
module exhaustive_stim_capture
    import exhaustive_stim_pkg::*;
#(
    parameter int               N_IN        = 2,
    parameter int               N_OUT       = 1,
    parameter int               HOLD_CYCLES = 1,
    parameter int               SIG_W       = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEF_POLY)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  pat,
    input  logic [N_OUT-1:0] resp,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [N_IN-1:0]  cap_pat,
    output logic [N_OUT-1:0] cap_resp,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam int              HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    stim_state_t     state;
    logic [HC_W-1:0] hold_cnt;
    logic            abort_take;

    // abort is meaningless in IDLE, so start there still wins
    assign abort_take = abort && (state != IDLE);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pat       <= '0;
            hold_cnt  <= '0;
            cap_valid <= 1'b0;
            cap_pat   <= '0;
            cap_resp  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort_take) begin
            state     <= IDLE;
            pat       <= '0;
            hold_cnt  <= '0;
            cap_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= APPLY;
                        pat      <= '0;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                APPLY: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        cap_resp  <= resp;
                        cap_pat   <= pat;
                        cap_valid <= 1'b1;
                        state     <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (cap_ready) begin
                        cap_valid <= 1'b0;
                        if (&pat) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pat      <= pat + 1'b1;
                            hold_cnt <= '0;
                            state    <= APPLY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXHAUSTIVE_STIM_CAPTURE_MISR_EN
    logic start_take;
    logic accept;

    assign start_take = start && ((state == IDLE) || ((state == DONE) && !abort));
    assign accept     = (state == SAMPLE) && cap_valid && cap_ready && !abort;

    stim_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .N_OUT (N_OUT)
    ) u_misr (
        .clk   (CK),
        .reset (reset),
        .clr   (start_take),
        .en    (accept),
        .data  (cap_resp),
        .sig   (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// tb/tb_exhaustive_stim_capture.sv - scoreboard bench for exhaustive_stim_capture
module tb_exhaustive_stim_capture;

`ifdef EXHAUSTIVE_STIM_CAPTURE_MISR_EN
    localparam int EXP_SIG_AND   = 1;
    localparam int EXP_SIG_XOR   = 6;
    localparam int EXP_SIG_ABORT = 1;
`else
    localparam int EXP_SIG_AND   = 0;
    localparam int EXP_SIG_XOR   = 0;
    localparam int EXP_SIG_ABORT = 0;
`endif

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic        reset;
    logic        start2, abort2, cap_ready2, use_xor;
    logic [1:0]  pat2, cap_pat2;
    logic        resp2, cap_resp2, cap_valid2, busy2, done2;
    logic [15:0] sig2;

    logic        start3, abort3, cap_ready3;
    logic [2:0]  pat3, cap_pat3;
    logic [1:0]  resp3, cap_resp3;
    logic        cap_valid3, busy3, done3;
    logic [15:0] sig3;

    assign resp2 = use_xor ? (pat2[0] ^ pat2[1]) : (pat2[0] & pat2[1]);
    assign resp3 = {pat3[2], ^pat3};

    exhaustive_stim_capture #(.N_IN(2), .N_OUT(1), .HOLD_CYCLES(1)) u_dut2 (
        .CK(CK), .reset(reset), .start(start2), .abort(abort2), .pat(pat2), .resp(resp2),
        .cap_valid(cap_valid2), .cap_ready(cap_ready2), .cap_pat(cap_pat2), .cap_resp(cap_resp2),
        .busy(busy2), .done(done2), .signature(sig2)
    );

    exhaustive_stim_capture #(.N_IN(3), .N_OUT(2), .HOLD_CYCLES(3)) u_dut3 (
        .CK(CK), .reset(reset), .start(start3), .abort(abort3), .pat(pat3), .resp(resp3),
        .cap_valid(cap_valid3), .cap_ready(cap_ready3), .cap_pat(cap_pat3), .cap_resp(cap_resp3),
        .busy(busy3), .done(done3), .signature(sig3)
    );

    int n_vec = 0;
    int n_err = 0;
    int q2[$];
    int q3[$];
    int and_tbl[4] = '{0, 0, 0, 1};
    int xor_tbl[4] = '{0, 1, 1, 0};
    int tbl3[8]    = '{0, 1, 1, 0, 3, 2, 2, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CK) begin
        if (cap_valid2 === 1'b1 && cap_ready2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rec2_extra: got pat %0d resp %0d, expected no record", cap_pat2, cap_resp2);
            end else begin
                int e;
                e = q2.pop_front();
                chk("rec2_pat", 32'(cap_pat2), 32'(e >> 4));
                chk("rec2_resp", 32'(cap_resp2), 32'(e & 15));
            end
        end
    end

    always @(negedge CK) begin
        if (cap_valid3 === 1'b1 && cap_ready3 === 1'b1) begin
            if (q3.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rec3_extra: got pat %0d resp %0d, expected no record", cap_pat3, cap_resp3);
            end else begin
                int e;
                e = q3.pop_front();
                chk("rec3_pat", 32'(cap_pat3), 32'(e >> 4));
                chk("rec3_resp", 32'(cap_resp3), 32'(e & 15));
            end
        end
    end

    task automatic push2();
        for (int i = 0; i < 4; i++)
            q2.push_back(i * 16 + (use_xor ? xor_tbl[i] : and_tbl[i]));
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic run2(input bit bp, input int exp_done);
        int cyc;
        int stalls;
        push2();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("sig2_cleared_on_start", 32'(sig2), 0);
        chk("busy2_after_start", 32'(busy2), 1);
        cyc = 0;
        stalls = 0;
        while (done2 !== 1'b1 && cyc < 100) begin
            cap_ready2 = 1'b1;
            if (bp && cap_valid2 && cap_pat2 == 2'd1 && stalls < 3) begin
                cap_ready2 = 1'b0;
                stalls++;
                chk("stall_pat", 32'(pat2), 1);
                chk("stall_cap_pat", 32'(cap_pat2), 1);
                chk("stall_cap_resp", 32'(cap_resp2), 32'(use_xor ? xor_tbl[1] : and_tbl[1]));
            end
            step();
            cyc++;
        end
        cap_ready2 = 1'b1;
        chk(bp ? "done2_cycle_bp" : "done2_cycle", 32'(cyc), 32'(exp_done));
        chk("busy2_at_done", 32'(busy2), 0);
        chk("sig2_at_done", 32'(sig2), 32'(use_xor ? EXP_SIG_XOR : EXP_SIG_AND));
        chk("q2_drained", 32'(q2.size()), 0);
    endtask

    task automatic run3();
        int cyc;
        int last;
        logic [2:0] prev;
        for (int i = 0; i < 8; i++) q3.push_back(i * 16 + tbl3[i]);
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        cyc = 0;
        last = 0;
        prev = pat3;
        while (done3 !== 1'b1 && cyc < 200) begin
            start3 = (cyc == 10);
            step();
            cyc++;
            if (pat3 !== prev) begin
                chk("hold3_len", 32'(cyc - last), 4);
                last = cyc;
                prev = pat3;
            end
        end
        start3 = 1'b0;
        chk("done3_cycle", 32'(cyc), 32);
        chk("busy3_at_done", 32'(busy3), 0);
        chk("q3_drained", 32'(q3.size()), 0);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; cap_ready2 = 1'b1; use_xor = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; cap_ready3 = 1'b1;
        step();
        step();
        chk("rst_pat", 32'(pat2), 0);
        chk("rst_cap_valid", 32'(cap_valid2), 0);
        chk("rst_cap_pat", 32'(cap_pat2), 0);
        chk("rst_cap_resp", 32'(cap_resp2), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_done", 32'(done2), 0);
        chk("rst_sig", 32'(sig2), 0);
        reset = 1'b1;
        step();

        run2(1'b0, 8);
        run2(1'b1, 11);
        run3();

        // abort once pattern 10 is on the DUT
        use_xor = 1'b1;
        push2();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        cyc = 0;
        while (pat2 !== 2'd2 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("abort_reached_pat2", 32'(pat2), 2);
        abort2 = 1'b1;
        chk("abort_pending_records", 32'(q2.size()), 2);
        q2.delete();
        step();
        abort2 = 1'b0;
        chk("abort_pat", 32'(pat2), 0);
        chk("abort_busy", 32'(busy2), 0);
        chk("abort_done", 32'(done2), 0);
        chk("abort_cap_valid", 32'(cap_valid2), 0);
        chk("abort_sig_kept", 32'(sig2), 32'(EXP_SIG_ABORT));
        step();

        run2(1'b0, 8);

        // asynchronous reset in the middle of a cycle
        push2();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        cyc = 0;
        while (!(cap_valid2 === 1'b1 && cap_pat2 === 2'd2) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("mid_run_cap_pat", 32'(cap_pat2), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pat", 32'(pat2), 0);
        chk("async_rst_cap_valid", 32'(cap_valid2), 0);
        chk("async_rst_cap_pat", 32'(cap_pat2), 0);
        chk("async_rst_cap_resp", 32'(cap_resp2), 0);
        chk("async_rst_busy", 32'(busy2), 0);
        chk("async_rst_done", 32'(done2), 0);
        chk("async_rst_sig", 32'(sig2), 0);
        q2.delete();
        step();
        reset = 1'b1;
        step();
        step();
        chk("post_rst_idle_busy", 32'(busy2), 0);
        chk("post_rst_no_records", 32'(q2.size() + q3.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exhaustive_stim_capture.md
Name: exhaustive_stim_capture

Overview:
- Synthesizable stimulus/capture engine for trojan-detection benchmark runs.
- Walks every input pattern 0 .. 2^N_IN-1 into a device under test and holds each pattern HOLD_CYCLES clocks.
- Samples the DUT response and streams each (pattern, response) pair to a logger over a valid/ready handshake.
- Sits between the run controller and the DUT wrapper, and replaces fixed hand-written pattern sequences for any input width.

Parameters:
- N_IN, 2, DUT input width; 1..16.
- N_OUT, 1, DUT output width; 1..16.
- HOLD_CYCLES, 1, clocks each pattern is applied before sampling; >=1.
- SIG_W, 16, signature width; >= N_OUT; used only with MISR_EN.
- POLY, 16'h1021, MISR feedback polynomial, low SIG_W bits.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- abort  in  1  terminate the run; return to IDLE.
- pat  out  N_IN  pattern driven to the DUT.
- resp  in  N_OUT  DUT response.
- cap_valid  out  1  capture record available.
- cap_ready  in  1  logger accepts the record.
- cap_pat  out  N_IN  pattern of the current record.
- cap_resp  out  N_OUT  sampled response of the current record.
- busy  out  1  run in progress.
- done  out  1  run completed; held until next start or abort.
- signature  out  SIG_W  MISR value.

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE and the following outputs to 0: pat, cap_valid, cap_pat, cap_resp, busy, done, signature. The hold counter is also 0.
- States:
  - IDLE: start=1 -> APPLY. On that edge: pat=0, busy=1, done=0, hold counter=0, signature=0.
  - APPLY: the hold counter increments each clock. When counter == HOLD_CYCLES-1, on that edge:
    - resp -> cap_resp and pat -> cap_pat;
    - cap_valid=1;
    - state -> SAMPLE.
  - SAMPLE: pat stays stable; cap_valid, cap_pat and cap_resp stay stable until cap_valid&&cap_ready. On the accepting edge cap_valid=0, then:
    - if pat == all-ones: state -> DONE, busy=0, done=1, pat unchanged;
    - else: pat=pat+1, hold counter=0, state -> APPLY.
  - DONE: start=1 -> same action as start in IDLE (pat=0, busy=1, done=0, hold counter=0, signature=0; state -> APPLY).
- start in APPLY or SAMPLE is ignored.
- abort=1 in any state except IDLE takes priority over every other transition. On that edge:
  - state -> IDLE;
  - busy=0, done=0, cap_valid=0, pat=0;
  - signature is kept.
- Pattern increment is modulo 2^N_IN. Wrap never occurs within a run because all-ones terminates it.
- Timing with cap_ready tied 1: one pattern per HOLD_CYCLES+1 clocks. The done rise comes 2^N_IN*(HOLD_CYCLES+1) clocks after the start edge.
- The response is sampled HOLD_CYCLES clocks after pat changes. The DUT combinational path must settle within that window.

Optional Feature:
- Macro: EXHAUSTIVE_STIM_CAPTURE_MISR_EN.
- Defined: on each accepting edge (cap_valid&&cap_ready), signature = (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended cap_resp. Cleared on start.
- Not defined: signature is tied to 0, and no MISR logic is synthesized.

Decomposition:
- Package exhaustive_stim_pkg holds:
  - the state enum type (IDLE, APPLY, SAMPLE, DONE);
  - default constants DEF_POLY=16'h1021 and DEF_SIG_W=16.
- Sub-module stim_misr (parameters SIG_W, POLY, N_OUT):
  - inputs: clr, en, data;
  - output: sig;
  - instantiated only under the macro.

Test Plan:
- Exhaustive AND: N_IN=2, HOLD_CYCLES=1, cap_ready=1, DUT = AND of inputs; pulse start. Required: records (00,0),(01,0),(10,0),(11,1) in order; done rises 8 clocks after the start edge; busy=0 with done.
- Backpressure: same setup, cap_ready=0 for 3 clocks while cap_pat=01. Required: pat, cap_pat and cap_resp stable during the stall; no record lost or duplicated; done rises at clock 11.
- Hold timing: HOLD_CYCLES=3, N_IN=3. Required: each pat value is held 4 clocks; 8 records; done rises at clock 32; start pulsed mid-run has no effect.
- Abort and reset: abort at pattern 10. Required: IDLE next edge with pat=0, busy=0, done=0, cap_valid=0; a restart begins again at 00. reset=0 asserted mid-run clears all outputs immediately, without waiting for a CK edge.
- MISR (macro defined): DUT = XOR, N_IN=2, so resp sequence is 0,1,1,0. Required: signature 0,1,3,6; final 16'h0006 at done. Without the macro, signature stays 0.
